deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/serdes_pkg.sv | 11 +
 rtl/deserializer.sv | 101 ++++++++++
 tb/tb_deserializer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared serdes types: receiver FSM states and minimum emitted frame length.
package serdes_pkg;

    typedef enum logic {
        IDLE_S = 1'b0,
        RECV_S = 1'b1
    } state_t;

    localparam int MIN_FRAME_LEN = 3;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer, MSB first, left-aligned output words.
// Optional DESERIALIZER_PARTIAL_EN emits gap-terminated words of >= 3 bits.
module deserializer
    import serdes_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      srst_n_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o
);

    localparam int CNT_W = $clog2(DATA_BUS_WIDTH + 1);

    state_t                    state_q;
    state_t                    state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_BUS_WIDTH-1:0] shreg_q;
    logic [DATA_BUS_WIDTH-1:0] shift_next;
    logic                      last_bit;
    logic [DATA_BUS_WIDTH-1:0] data_q;
    logic                      val_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE_S:  if (ser_data_val_i)  state_d = RECV_S;
            RECV_S:  if (!ser_data_val_i) state_d = IDLE_S;
            default: state_d = IDLE_S;
        endcase
    end

    assign shift_next = {shreg_q[DATA_BUS_WIDTH-2:0], ser_data_i};
    assign last_bit   = ser_data_val_i
                        && (cnt_q == CNT_W'(DATA_BUS_WIDTH - 1));

`ifdef DESERIALIZER_PARTIAL_EN
    logic [DATA_MOD_WIDTH-1:0] mod_q;
    logic                      gap_emit;

    // A gap ends the frame; short fragments are treated as line noise.
    assign gap_emit = (state_q == RECV_S) && !ser_data_val_i
                      && (cnt_q >= CNT_W'(MIN_FRAME_LEN));

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            mod_q <= '0;
        end else if (last_bit) begin
            mod_q <= '0;
        end else if (gap_emit) begin
            mod_q <= DATA_MOD_WIDTH'(cnt_q);
        end
    end

    assign deser_data_mod_o = mod_q;
`else
    assign deser_data_mod_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= IDLE_S;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= 1'b0;
            if (ser_data_val_i) begin
                if (last_bit) begin
                    data_q  <= shift_next;
                    val_q   <= 1'b1;
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end else begin
                    shreg_q <= shift_next;
                    cnt_q   <= cnt_q + 1'b1;
                end
            end else begin
`ifdef DESERIALIZER_PARTIAL_EN
                if (gap_emit) begin
                    data_q <= shreg_q << (CNT_W'(DATA_BUS_WIDTH) - cnt_q);
                    val_q  <= 1'b1;
                end
`endif
                cnt_q   <= '0;
                shreg_q <= '0;
            end
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (16-bit bus).
// Expectations follow DESERIALIZER_PARTIAL_EN when it is defined.
module tb_deserializer;

    logic        clk;
    logic        srst_n;
    logic        din;
    logic        vin;
    logic [15:0] dout;
    logic [3:0]  mod;
    logic        vout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sq[$];
    logic [15:0] dq[$];

    deserializer #(
        .DATA_BUS_WIDTH(16),
        .DATA_MOD_WIDTH(4)
    ) dut (
        .clk_i           (clk),
        .srst_n_i        (srst_n),
        .ser_data_i      (din),
        .ser_data_val_i  (vin),
        .deser_data_o    (dout),
        .deser_data_mod_o(mod),
        .deser_data_val_o(vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vout) begin
            sq.push_back(cyc);
            dq.push_back(dout);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            din = w[15-i];
            vin = 1'b1;
            step();
        end
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        din = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    int n0;
    int c1;
    logic [15:0] keep_d;
    logic [3:0]  keep_m;

    initial begin
        srst_n = 1'b0;
        din    = 1'b0;
        vin    = 1'b0;
        repeat (3) step();
        check("rst_data", dout, 0);
        check("rst_mod", mod, 0);
        check("rst_val", vout, 0);
        srst_n = 1'b1;
        step();

        // full word, strobe one cycle after the last bit
        n0 = sq.size();
        send(16'hA5C3, 16);
        check("full_val", vout, 1);
        check("full_data", dout, 16'hA5C3);
        check("full_mod", mod, 0);
        idle(1);
        check("full_val_drop", vout, 0);
        check("full_data_hold", dout, 16'hA5C3);
        idle(2);
        check("full_count", sq.size() - n0, 1);

        // back-to-back words
        n0 = sq.size();
        send(16'h1234, 16);
        send(16'hFFFF, 16);
        idle(3);
        check("b2b_count", sq.size() - n0, 2);
        if (sq.size() - n0 == 2) begin
            c1 = sq[n0];
            check("b2b_gap", sq[n0+1] - c1, 16);
            check("b2b_d0", dq[n0], 16'h1234);
            check("b2b_d1", dq[n0+1], 16'hFFFF);
        end
        check("b2b_mod", mod, 0);

        // 5-bit partial frame 10110
        n0 = sq.size();
        send(16'hB000, 5);
        idle(1);
`ifdef DESERIALIZER_PARTIAL_EN
        check("p5_val", vout, 1);
        check("p5_data", dout, 16'hB000);
        check("p5_mod", mod, 5);
        idle(2);
        check("p5_count", sq.size() - n0, 1);
`else
        check("p5_val", vout, 0);
        check("p5_data", dout, 16'hFFFF);
        check("p5_mod", mod, 0);
        idle(2);
        check("p5_count", sq.size() - n0, 0);
`endif

        // 2-bit fragment is always dropped
        keep_d = dout;
        keep_m = mod;
        n0 = sq.size();
        send(16'hC000, 2);
        idle(3);
        check("p2_count", sq.size() - n0, 0);
        check("p2_data", dout, keep_d);
        check("p2_mod", mod, keep_m);

        // new word starts in the cycle a partial word is emitted
        n0 = sq.size();
        send(16'hF000, 4);
        idle(1);
`ifdef DESERIALIZER_PARTIAL_EN
        check("p4_val", vout, 1);
        check("p4_data", dout, 16'hF000);
        check("p4_mod", mod, 4);
`else
        check("p4_val", vout, 0);
`endif
        send(16'h5A5A, 16);
        check("nx_val", vout, 1);
        check("nx_data", dout, 16'h5A5A);
        check("nx_mod", mod, 0);
        idle(2);
`ifdef DESERIALIZER_PARTIAL_EN
        check("nx_count", sq.size() - n0, 2);
`else
        check("nx_count", sq.size() - n0, 1);
`endif

        // reset in the middle of a frame
        n0 = sq.size();
        send(16'hABCD, 8);
        srst_n = 1'b0;
        vin    = 1'b0;
        step();
        check("mr_data", dout, 0);
        check("mr_mod", mod, 0);
        check("mr_val", vout, 0);
        step();
        srst_n = 1'b1;
        idle(2);
        check("mr_count", sq.size() - n0, 0);
        send(16'h00FF, 16);
        check("ar_val", vout, 1);
        check("ar_data", dout, 16'h00FF);
        check("ar_mod", mod, 0);
        idle(2);
        check("ar_count", sq.size() - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
